// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide (one bit per cycle).
module seq_alu #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     Start,
    input  logic                     Kill,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     Busy,
    output logic                     Done,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    localparam int DW  = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIXUP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                     r_pend;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic [DW-1:0]            r_a;
    logic [DW-1:0]            r_b;
    logic [DW-1:0]            r_hi;
    logic [DW-1:0]            r_lo;
    logic [DW-1:0]            r_m;
    logic [SHW-1:0]           r_cnt;
    logic                     r_done;
    logic [DW-1:0]            r_result;

    logic                     w_is_iter;
    logic [2:0]               w_kind;
    logic                     w_is_mul;
    logic                     w_signed;
    logic                     w_sa;
    logic                     w_sb;
    logic [DW-1:0]            w_mag_a;
    logic [DW-1:0]            w_mag_b;
    logic                     w_accept;
    logic                     w_start_iter;
    logic                     w_finish_single;
    logic                     w_last;
    logic [SHW-1:0]           w_sh;
    logic [DW-1:0]            w_alu;
    logic [DW:0]              w_sum;
    logic [DW:0]              w_shl;
    logic [DW:0]              w_diff;
    logic                     w_ge;
    logic [DW-1:0]            w_hi_n;
    logic [DW-1:0]            w_lo_n;
    logic [DW-1:0]            w_mulh_neg;
    logic [DW-1:0]            w_iter_res;

    assign w_is_iter = (r_op >= OPCODE_LENGTH'(16)) &&
                       (r_op <= OPCODE_LENGTH'(22));
    assign w_kind    = r_op[2:0];
    assign w_is_mul  = (w_kind < 3'd3);
    assign w_signed  = (w_kind == 3'd1) || (w_kind == 3'd3) ||
                       (w_kind == 3'd5);
    assign w_sa      = w_signed && r_a[DW-1];
    assign w_sb      = w_signed && r_b[DW-1];
    assign w_mag_a   = w_sa ? -r_a : r_a;
    assign w_mag_b   = w_sb ? -r_b : r_b;

    // An accepted iterative request occupies the cycle before Busy rises
    assign w_accept = Start && !Kill && (r_state == IDLE) &&
                      !(r_pend && w_is_iter);
    assign w_start_iter    = r_pend && w_is_iter && !Kill &&
                             (r_state == IDLE);
    assign w_finish_single = r_pend && !w_is_iter && !Kill;
    assign w_last          = (r_cnt == SHW'(DW - 1));
    assign w_sh            = r_b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        if (r_op < OPCODE_LENGTH'(16)) begin
            unique case (r_op[3:0])
                4'h0: w_alu = r_a & r_b;
                4'h1: w_alu = r_a ^ r_b;
                4'h2: w_alu = r_a + r_b;
                4'h3: w_alu = DW'($signed(r_a) < $signed(r_b));
                4'h4: w_alu = DW'(r_a != r_b);
                4'h5: w_alu = r_a | r_b;
                4'h6: w_alu = r_a << w_sh;
                4'h7: w_alu = $signed(r_a) >>> w_sh;
                4'h8: w_alu = DW'(r_a == r_b);
                4'h9: w_alu = r_b;
                4'hA: w_alu = r_a - r_b;
                4'hB: w_alu = r_a + r_b;
                4'hC: w_alu = DW'($signed(r_a) < $signed(r_b));
                4'hD: w_alu = DW'($signed(r_a) < $signed(r_b));
                4'hE: w_alu = r_a >> w_sh;
                4'hF: w_alu = DW'($signed(r_a) >= $signed(r_b));
            endcase
        end
    end

    // One multiply or divide step on the {r_hi, r_lo} working pair
    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    assign w_shl  = {r_hi, r_lo[DW-1]};
    assign w_diff = w_shl - {1'b0, r_m};
    assign w_ge   = !w_diff[DW];

    always_comb begin
        if (w_is_mul) begin
            w_hi_n = w_sum[DW:1];
            w_lo_n = {w_sum[0], r_lo[DW-1:1]};
        end else begin
            w_hi_n = w_ge ? w_diff[DW-1:0] : w_shl[DW-1:0];
            w_lo_n = {r_lo[DW-2:0], w_ge};
        end
    end

    assign w_mulh_neg = ~r_hi + DW'(r_lo == '0);

    always_comb begin
        w_iter_res = '0;
        case (w_kind)
            3'd0: w_iter_res = r_lo;
            3'd1: w_iter_res = (w_sa ^ w_sb) ? w_mulh_neg : r_hi;
            3'd2: w_iter_res = r_hi;
            3'd3: begin
                if (r_b == '0)
                    w_iter_res = '1;
                else
                    w_iter_res = (w_sa ^ w_sb) ? -r_lo : r_lo;
            end
            3'd4: w_iter_res = r_lo;
            3'd5: begin
                if (r_b == '0)
                    w_iter_res = r_a;
                else
                    w_iter_res = w_sa ? -r_hi : r_hi;
            end
            3'd6: w_iter_res = r_hi;
            default: w_iter_res = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_iter)
                    w_next = ITER;
            end
            ITER: begin
                if (Kill)
                    w_next = IDLE;
                else if (w_last)
                    w_next = FIXUP;
            end
            FIXUP:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
        end else begin
            r_pend <= w_accept;
            if (w_accept) begin
                r_op <= Operation;
                r_a  <= SrcA;
                r_b  <= SrcB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_m   <= '0;
            r_cnt <= '0;
        end else if (w_start_iter) begin
            r_hi  <= '0;
            r_lo  <= w_mag_a;
            r_m   <= w_mag_b;
            r_cnt <= '0;
        end else if (r_state == ITER) begin
            if (Kill) begin
                r_cnt <= '0;
            end else begin
                r_hi  <= w_hi_n;
                r_lo  <= w_lo_n;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_finish_single) begin
                r_result <= w_alu;
                r_done   <= 1'b1;
            end else if ((r_state == FIXUP) && !Kill) begin
                r_result <= w_iter_res;
                r_done   <= 1'b1;
            end
        end
    end

    assign Busy      = (r_state != IDLE);
    assign Done      = r_done;
    assign ALUResult = r_result;

endmodule
